hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline stall/halt controller for the five-stage MIPS core: consumes the per-cycle hazard verdict from `risk_detection` (`not_load`, `halt`, `ctr_reg_src`) plus the ID-stage branch-taken flag, and drives the PC, IF/ID and ID/EX register controls. It also sequences program end: freezes fetch on a HALT opcode, drains the instructions already in flight through EX/MEM/WB, then raises `o_end_program` to the debug unit. It sits between the hazard unit and the pipeline registers and honours the debug unit's step/run enable.

## Interface
- `DRAIN_CYCLES`, 3: enabled cycles needed to retire the in-flight instructions after HALT reaches ID; legal range 1..15.
- `MAX_STALL`, 4: consecutive enabled stall cycles that flag `o_stall_error`; legal range 2..15.
- `CNT_W`, 16: width of the stall statistics counter.
- `i_clk` in 1: single clock; all state updates on the rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_enable` in 1: debug-unit enable; when 0 the pipeline is frozen.
- `i_not_load` in 1: 1 = load-use/data hazard; PC and IF/ID must not load this cycle.
- `i_halt` in 1: 1 = HALT opcode in ID.
- `i_ctr_reg_src` in 1: 1 = zero the ID/EX control word (bubble).
- `i_branch_taken` in 1: 1 = branch/jump resolved taken in ID.
- `o_pc_write` out 1: PC load enable.
- `o_if_id_write` out 1: IF/ID load enable.
- `o_if_id_flush` out 1: clear IF/ID (squash the wrong-path fetch).
- `o_id_ex_bubble` out 1: load NOP control into ID/EX.
- `o_end_program` out 1: registered; program finished and pipeline drained.
- `o_stall_error` out 1: registered, sticky; stall watchdog tripped.
- `o_stall_count` out CNT_W: registered; total enabled stall cycles, saturating.
- `o_state` out 2: registered FSM state (RUN=0, DRAIN=1, HALTED=2).

## Operation
- FSM states: RUN, DRAIN, HALTED. The encoding 3 is unreachable and decodes as HALTED.
- RUN, `i_enable`=1, priority order:
  - `i_halt`=1: `o_pc_write`=0 and `o_if_id_write`=0; `o_id_ex_bubble`=1; `o_if_id_flush`=0. Next state is DRAIN and the drain counter loads `DRAIN_CYCLES`.
  - Otherwise `i_not_load`=1: `o_pc_write`=0, `o_if_id_write`=0, `o_id_ex_bubble`=1, `o_if_id_flush`=0. `i_branch_taken` is ignored.
  - Otherwise: `o_pc_write`=1, `o_if_id_write`=1, `o_id_ex_bubble`=`i_ctr_reg_src`, `o_if_id_flush`=`i_branch_taken`.
- DRAIN, `i_enable`=1: PC and IF/ID writes are 0, bubble is 1, flush is 0. The drain counter decrements each cycle. When the counter is 1, the next state is HALTED.
- HALTED: all four control outputs are 0. `o_end_program`=1. The state is held until reset.
- `i_enable`=0 in any state: all four control outputs are 0. FSM, drain counter, watchdog and statistics all hold.
- Stall statistics: `o_stall_count` increments on each enabled RUN cycle with `i_not_load`=1 and `i_halt`=0. It saturates at all-ones.
- Watchdog: a consecutive-stall counter counts the same cycles and clears on any enabled RUN cycle with `i_not_load`=0. When it reaches `MAX_STALL`, `o_stall_error` sets and stays set until reset.

## Timing
- Control outputs (`o_pc_write`, `o_if_id_write`, `o_if_id_flush`, `o_id_ex_bubble`) are combinational from the inputs and the registered state. They take effect at the same rising edge as the hazard they answer, with zero-cycle latency.
- While `i_reset`=1, all control outputs are forced to 0.
- Reset values: `o_state`=RUN, drain counter 0, `o_end_program`=0, `o_stall_error`=0, `o_stall_count`=0, consecutive-stall counter 0.
- HALT sampled in RUN at edge N gives DRAIN from N. `o_end_program` rises at edge N+`DRAIN_CYCLES`, assuming `i_enable` stays high.
- Every cycle with `i_enable` low extends that latency by exactly one cycle.
- `i_halt` and `i_not_load` high together: halt wins. The cycle is not counted as a stall, and the state goes to DRAIN.
- Inputs are ignored in DRAIN and HALTED. A new HALT during DRAIN does not reload the counter.
- Reset asserted mid-DRAIN: the FSM returns to RUN immediately (asynchronous) and `o_end_program` stays 0.

## Test plan
- Reset then RUN with all inputs 0 and `i_enable`=1 -> `o_pc_write`=`o_if_id_write`=1, bubble=0, flush=0, `o_state`=0.
- `i_not_load`=1 for 1 cycle -> that cycle PC and IF/ID writes are 0 and bubble=1; `o_stall_count`=1 after the edge; `o_stall_error`=0.
- `i_not_load`=1 for 4 consecutive enabled cycles (`MAX_STALL`=4) -> `o_stall_error`=1 after the 4th edge; it stays 1 after `i_not_load` drops.
- `i_branch_taken`=1 with `i_not_load`=0 -> flush=1 with writes=1. With `i_not_load`=1 as well -> flush=0 and bubble=1.
- `i_halt` and `i_not_load` both 1 at edge N (`DRAIN_CYCLES`=3) -> `o_state`=1 after N, `o_end_program`=1 after N+3, and `o_stall_count` is unchanged.
- HALT, then `i_enable`=0 for 2 cycles during DRAIN -> `o_end_program` is delayed to N+5. Then assert `i_reset` -> `o_state`=0 and `o_end_program`=0 immediately.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-verdict / pipeline-control bundle between the hazard unit,
// the debug unit and the stall controller.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             i_enable;
    logic             i_not_load;
    logic             i_halt;
    logic             i_ctr_reg_src;
    logic             i_branch_taken;
    logic             o_pc_write;
    logic             o_if_id_write;
    logic             o_if_id_flush;
    logic             o_id_ex_bubble;
    logic             o_end_program;
    logic             o_stall_error;
    logic [CNT_W-1:0] o_stall_count;
    logic [1:0]       o_state;

    // Side that supplies the hazard verdict and observes the pipeline controls.
    modport master (
        output i_enable, i_not_load, i_halt, i_ctr_reg_src, i_branch_taken,
        input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble,
               o_end_program, o_stall_error, o_stall_count, o_state
    );

    // The stall controller itself.
    modport slave (
        input  i_enable, i_not_load, i_halt, i_ctr_reg_src, i_branch_taken,
        output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble,
               o_end_program, o_stall_error, o_stall_count, o_state
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/halt controller: turns the hazard verdict into PC, IF/ID
// and ID/EX controls, sequences HALT -> drain -> end of program, and keeps
// stall statistics plus a consecutive-stall watchdog.
module hazard_stall_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MAX_STALL    = 4,
    parameter int CNT_W        = 16
) (
    input logic                i_clk,
    input logic                i_reset,
    hazard_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [3:0]       DRAIN_INIT  = 4'(DRAIN_CYCLES);
    localparam logic [3:0]       STALL_LIMIT = 4'(MAX_STALL);
    localparam logic [CNT_W-1:0] COUNT_MAX   = '1;

    state_t           state;
    logic [3:0]       drain_cnt;
    logic [3:0]       run_len;
    logic             end_program;
    logic             stall_error;
    logic [CNT_W-1:0] stall_count;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;

    // Zero-latency pipeline controls from the live hazard verdict and state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (!i_reset && bus.i_enable) begin
            case (state)
                RUN: begin
                    if (bus.i_halt || bus.i_not_load) begin
                        id_ex_bubble = 1'b1;
                    end else begin
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        id_ex_bubble = bus.i_ctr_reg_src;
                        if_id_flush  = bus.i_branch_taken;
                    end
                end
                DRAIN:   id_ex_bubble = 1'b1;
                default: ;  // HALTED, and the unused encoding 3, drive nothing
            endcase
        end
    end

    // FSM, drain countdown, stall statistics and watchdog; all frozen while disabled.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= RUN;
            drain_cnt   <= '0;
            run_len     <= '0;
            end_program <= 1'b0;
            stall_error <= 1'b0;
            stall_count <= '0;
        end else if (bus.i_enable) begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            case (state)
                RUN: begin
                    if (bus.i_halt) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_INIT;
                    end else if (bus.i_not_load) begin
                        if (stall_count != COUNT_MAX) begin
                            stall_count <= stall_count + 1'b1;
                        end
                        // Cap the run length at the limit so it can never wrap.
                        if (run_len < STALL_LIMIT) begin
                            run_len <= run_len + 4'd1;
                        end
                        if (run_len >= STALL_LIMIT - 4'd1) begin
                            stall_error <= 1'b1;
                        end
                    end else begin
                        run_len <= '0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - 4'd1;
                    if (drain_cnt == 4'd1) begin
                        state       <= HALTED;
                        end_program <= 1'b1;
                    end
                end
                default: ;  // HALTED holds until reset
            endcase
        end
    end

    assign bus.o_pc_write     = pc_write;
    assign bus.o_if_id_write  = if_id_write;
    assign bus.o_if_id_flush  = if_id_flush;
    assign bus.o_id_ex_bubble = id_ex_bubble;
    assign bus.o_end_program  = end_program;
    assign bus.o_stall_error  = stall_error;
    assign bus.o_stall_count  = stall_count;
    assign bus.o_state        = state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed steps from the test
// plan followed by randomized traffic, all compared against a behavioural model.
module tb_hazard_stall_ctrl;

    localparam int DRAIN_CYCLES = 3;
    localparam int MAX_STALL    = 4;
    localparam int CNT_W        = 4;  // small so saturation is reachable
    localparam int COUNT_MAX    = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_ctrl #(
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .MAX_STALL   (MAX_STALL),
        .CNT_W       (CNT_W)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: program life measured in enabled edges since HALT.
    bit m_halt_seen;
    int m_after_halt;
    int m_stalls;
    int m_run;
    bit m_err;

    function automatic int exp_state();
        if (!m_halt_seen) return 0;
        if (m_after_halt < DRAIN_CYCLES) return 1;
        return 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_halt_seen  = 1'b0;
        m_after_halt = 0;
        m_stalls     = 0;
        m_run        = 0;
        m_err        = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit nl, input bit h);
        if (rst || !en) return;
        if (m_halt_seen) begin
            m_after_halt++;
        end else if (h) begin
            m_halt_seen  = 1'b1;
            m_after_halt = 0;
        end else if (nl) begin
            if (m_stalls < COUNT_MAX) m_stalls++;
            m_run++;
            if (m_run >= MAX_STALL) m_err = 1'b1;
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check_comb(input string tag);
        bit pc, ifid, fl, bub;
        pc = 0; ifid = 0; fl = 0; bub = 0;
        if (!rst && bus.i_enable) begin
            if (exp_state() == 0) begin
                if (bus.i_halt || bus.i_not_load) begin
                    bub = 1;
                end else begin
                    pc   = 1;
                    ifid = 1;
                    bub  = bus.i_ctr_reg_src;
                    fl   = bus.i_branch_taken;
                end
            end else if (exp_state() == 1) begin
                bub = 1;
            end
        end
        check({tag, ".pc_write"},     32'(bus.o_pc_write),     32'(pc));
        check({tag, ".if_id_write"},  32'(bus.o_if_id_write),  32'(ifid));
        check({tag, ".if_id_flush"},  32'(bus.o_if_id_flush),  32'(fl));
        check({tag, ".id_ex_bubble"}, 32'(bus.o_id_ex_bubble), 32'(bub));
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".state"},       32'(bus.o_state),       32'(exp_state()));
        check({tag, ".end_program"}, 32'(bus.o_end_program), 32'(exp_state() == 2));
        check({tag, ".stall_error"}, 32'(bus.o_stall_error), 32'(m_err));
        check({tag, ".stall_count"}, 32'(bus.o_stall_count), 32'(m_stalls));
    endtask

    // One clock: drive, check controls before the edge, check state after it.
    task automatic step(input string tag, input bit en, input bit nl, input bit h,
                        input bit crs, input bit bt);
        bus.i_enable       = en;
        bus.i_not_load     = nl;
        bus.i_halt         = h;
        bus.i_ctr_reg_src  = crs;
        bus.i_branch_taken = bt;
        #1;
        check_comb(tag);
        @(posedge clk);
        model_edge(en, nl, h);
        #1;
        check_regs(tag);
    endtask

    // Asynchronous reset: effect is checked immediately, released off-edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check_comb({tag, ".rst"});
        check_regs({tag, ".rst"});
        bus.i_enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                = 1'b0;
        bus.i_enable       = 1'b0;
        bus.i_not_load     = 1'b0;
        bus.i_halt         = 1'b0;
        bus.i_ctr_reg_src  = 1'b0;
        bus.i_branch_taken = 1'b0;
        model_reset();
        #2;
        do_reset("reset0");

        // Normal flow, single stall, watchdog trip and stickiness.
        step("run",        1, 0, 0, 0, 0);
        step("run2",       1, 0, 0, 0, 0);
        step("stall1",     1, 1, 0, 0, 0);
        step("unstall",    1, 0, 0, 0, 0);
        for (int i = 0; i < MAX_STALL; i++) step("stall_run", 1, 1, 0, 0, 0);
        step("err_sticky", 1, 0, 0, 0, 0);

        // Branch flush, flush suppressed by a stall, ctr_reg_src bubble, disable.
        step("branch",       1, 0, 0, 0, 1);
        step("branch_stall", 1, 1, 0, 0, 1);
        step("ctr_src",      1, 0, 0, 1, 0);
        step("disabled",     0, 1, 1, 1, 1);

        // Halt with not_load: halt wins; extra halts in DRAIN do not reload.
        step("halt_nl",   1, 1, 1, 0, 0);
        step("drain_h1",  1, 1, 1, 1, 1);
        step("drain_h2",  1, 1, 1, 1, 1);
        step("drain_end", 1, 0, 0, 0, 0);
        step("halted",    1, 1, 0, 1, 1);
        step("halted2",   1, 0, 1, 0, 1);

        // Halt with enable gaps in DRAIN, then reset while halted.
        do_reset("reset1");
        step("halt2",     1, 0, 1, 0, 0);
        step("drain_a",   1, 0, 0, 0, 0);
        step("gap1",      0, 0, 0, 0, 0);
        step("gap2",      0, 0, 0, 0, 0);
        step("drain_b",   1, 0, 0, 0, 0);
        step("drain_c",   1, 0, 0, 0, 0);
        step("halted3",   1, 0, 0, 0, 0);
        do_reset("reset_halted");

        // Reset in the middle of DRAIN.
        step("halt3",     1, 0, 1, 0, 0);
        step("drain_mid", 1, 0, 0, 0, 0);
        do_reset("reset_drain");

        // Saturate the stall counter.
        for (int i = 0; i < COUNT_MAX + 3; i++) step("saturate", 1, 1, 0, 0, 0);
        do_reset("reset2");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            bit en, nl, h, crs, bt;
            en  = ($urandom_range(7) != 0);
            nl  = ($urandom_range(2) == 0);
            h   = ($urandom_range(23) == 0);
            crs = $urandom_range(1);
            bt  = $urandom_range(1);
            step("rand", en, nl, h, crs, bt);
            if ((exp_state() == 2 && m_after_halt >= DRAIN_CYCLES + 2) ||
                $urandom_range(99) == 0) begin
                do_reset("rand_reset");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
